// File: rtl/mult_share_arb_pkg.sv
// Shared types and constants for the two-requester shared-multiplier arbiter.
package mult_share_arb_pkg;

    localparam int unsigned OP_CNT_W = 16;
    localparam int unsigned ST_W     = 2;

    typedef enum logic [ST_W-1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Two-way round-robin pick; last=1 means requester 1 was granted most recently.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
        logic [1:0] gnt;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        return gnt;
    endfunction

endpackage

// File: rtl/mult_share_arb_if.sv
// Requester and result handshake bundle for mult_share_arb.
interface mult_share_arb_if #(
    parameter int unsigned W = 32
);
    logic           req0_valid_i;
    logic [W-1:0]   req0_a_i;
    logic [W-1:0]   req0_b_i;
    logic           req0_ready_o;

    logic           req1_valid_i;
    logic [W-1:0]   req1_a_i;
    logic [W-1:0]   req1_b_i;
    logic           req1_ready_o;

    logic           res_valid_o;
    logic           res_id_o;
    logic [2*W-1:0] res_data_o;
    logic           res_ready_i;

    modport master (
        output req0_valid_i, req0_a_i, req0_b_i,
        input  req0_ready_o,
        output req1_valid_i, req1_a_i, req1_b_i,
        input  req1_ready_o,
        input  res_valid_o, res_id_o, res_data_o,
        output res_ready_i
    );

    modport slave (
        input  req0_valid_i, req0_a_i, req0_b_i,
        output req0_ready_o,
        input  req1_valid_i, req1_a_i, req1_b_i,
        output req1_ready_o,
        output res_valid_o, res_id_o, res_data_o,
        input  res_ready_i
    );

endinterface

// File: rtl/mul_comb.sv
// Combinational unsigned W x W -> 2W multiplier.
module mul_comb #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p_c
);
    localparam int unsigned PW = 2 * W;

    assign p_c = PW'(a) * PW'(b);

endmodule

// File: rtl/mult_share_arb_rr_grant2.sv
// Two-way round-robin grant; the pointer only moves when update is asserted.
module rr_grant2
    import mult_share_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    input  logic       update,
    output logic [1:0] gnt_c
);
    logic last_q;

    always_comb begin
        gnt_c = 2'b00;
        if (en) begin
            gnt_c = rr_pick(req, last_q);
        end
    end

    // Reset value 1 makes requester 0 win the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (update) begin
            last_q <= gnt_c[1];
        end
    end

endmodule

// File: rtl/mult_share_arb.sv
// Arbitrates two requesters onto one shared multiplier; one op in flight at a time.
module mult_share_arb
    import mult_share_arb_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic                clk,
    input  logic                rst,
    mult_share_arb_if.slave     bus,
    output logic                busy_o,
    output logic [OP_CNT_W-1:0] op_cnt_o
);
    localparam int unsigned PW = 2 * W;

    state_e              state_q;
    state_e              state_d;
    logic [W-1:0]        a_q;
    logic [W-1:0]        b_q;
    logic                id_q;
    logic [PW-1:0]       res_data_q;
    logic                res_id_q;
    logic [OP_CNT_W-1:0] op_cnt_q;

    logic [1:0]          gnt_c;
    logic [PW-1:0]       prod_c;
    logic                win_c;
    logic                hs_c;
    logic                ld_res_c;
    logic                res_hs_c;

    // Accept window: idle, or the current result leaves this cycle.
    assign win_c = !rst && ((state_q == IDLE) ||
                            ((state_q == DONE) && bus.res_ready_i));
    assign hs_c  = |gnt_c;

    rr_grant2 u_grant (
        .clk    (clk),
        .rst    (rst),
        .req    ({bus.req1_valid_i, bus.req0_valid_i}),
        .en     (win_c),
        .update (hs_c),
        .gnt_c  (gnt_c)
    );

    mul_comb #(.W(W)) u_mul (
        .a   (a_q),
        .b   (b_q),
        .p_c (prod_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ld_res_c = 1'b0;
        res_hs_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (hs_c) state_d = MUL;
            end
            MUL: begin
                ld_res_c = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                if (bus.res_ready_i) begin
                    res_hs_c = 1'b1;
                    state_d  = hs_c ? MUL : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, product capture and delivered-result count.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            res_data_q <= '0;
            res_id_q   <= 1'b0;
            op_cnt_q   <= '0;
        end else begin
            if (hs_c) begin
                a_q  <= gnt_c[1] ? bus.req1_a_i : bus.req0_a_i;
                b_q  <= gnt_c[1] ? bus.req1_b_i : bus.req0_b_i;
                id_q <= gnt_c[1];
            end
            if (ld_res_c) begin
                res_data_q <= prod_c;
                res_id_q   <= id_q;
            end
            if (res_hs_c) begin
                op_cnt_q <= op_cnt_q + OP_CNT_W'(1);
            end
        end
    end

    assign bus.req0_ready_o = gnt_c[0];
    assign bus.req1_ready_o = gnt_c[1];
    assign bus.res_valid_o  = (state_q == DONE);
    assign bus.res_id_o     = res_id_q;
    assign bus.res_data_o   = res_data_q;
    assign busy_o           = (state_q != IDLE);
    assign op_cnt_o         = op_cnt_q;

endmodule

// File: doc/mult_share_arb.md
MULT_SHARE_ARB -- requirements
Module: mult_share_arb

Interface
REQ-001 Parameter W, default 32, operand width of both requesters and of the shared multiplier.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid_i  input  1  requester 0 holds an operation.
REQ-005 req0_a_i, req0_b_i  input  W each  requester 0 operands.
REQ-006 req0_ready_o  output  1  requester 0 operation accepted this cycle when high with req0_valid_i.
REQ-007 req1_valid_i, req1_a_i, req1_b_i, req1_ready_o  same as REQ-004..006 for requester 1.
REQ-008 res_valid_o  output  1  result available.
REQ-009 res_id_o  output  1  requester index owning the result.
REQ-010 res_data_o  output  2W  unsigned product.
REQ-011 res_ready_i  input  1  consumer takes the result when high with res_valid_o.
REQ-012 busy_o  output  1  high in any state other than IDLE.
REQ-013 op_cnt_o  output  16  count of delivered results, wraps 0xFFFF->0x0000.

Function
REQ-014 FSM states: IDLE, MUL, DONE.
REQ-015 Accept window: state IDLE, or state DONE with res_ready_i=1.
REQ-016 In the accept window, a single valid requester is granted; with both valid, the requester not granted last is granted (round-robin); only the granted requester's ready_o is high; ready_o may depend combinationally on valid_i.
REQ-017 Outside the accept window, both ready_o are 0.
REQ-018 On handshake: operands registered, id registered, last-grant pointer updated, next state MUL.
REQ-019 MUL: registered operands drive the shared multiplier; full 2W-bit product registered into res_data_o; next state DONE; exactly one cycle.
REQ-020 Latency: handshake at edge t -> res_valid_o=1 from cycle t+2; no truncation; W-bit x W-bit unsigned.
REQ-021 DONE: res_valid_o=1; res_data_o and res_id_o stable until handshake.
REQ-022 DONE with res_ready_i=0: hold; no grant.
REQ-023 DONE with res_ready_i=1: op_cnt_o increments; if a request is granted in the same cycle -> MUL, else -> IDLE.
REQ-024 A requester deasserting valid_i before handshake forfeits its turn; the pointer changes only on handshake.
REQ-025 res_valid_o=0 in IDLE and MUL.

Reset
REQ-026 rst has priority over all other inputs and forces state IDLE, res_valid_o=0, res_id_o=0, res_data_o=0, op_cnt_o=0, busy_o=0, and a last-grant pointer that favours requester 0 on the first contention.
REQ-027 rst asserted in MUL or DONE discards the in-flight operation; no result and no count increment.
REQ-028 Both ready_o are 0 while rst=1.

Structure
REQ-029 Shared package: the FSM state encoding constants (IDLE, MUL, DONE) and the op_cnt_o width constant (16).
REQ-030 One sub-module, rr_grant2: a two-way round-robin grant with a pointer-update input.
REQ-031 The multiply is an instance of the codebase's combinational W-bit multiplier; this block adds no other arithmetic.

Verification
REQ-032 The bench covers these five directed scenarios:
- Single op: req0 a=3, b=5 handshake at t -> res_valid_o at t+2, res_data_o=15, res_id_o=0, op_cnt_o=1 after res handshake.
- Contention: both valid continuously, res_ready_i=1 -> grants alternate 0,1,0,1; first grant after reset goes to 0.
- Back-pressure: res_ready_i=0 for 10 cycles in DONE -> result stable, both ready_o=0; releasing res_ready_i with req1 valid gives res handshake and req1 grant in the same cycle.
- Max width: a=b=0xFFFFFFFF -> res_data_o=0xFFFFFFFE00000001.
- Reset mid-op: rst in MUL -> next cycle IDLE, res_valid_o=0, op_cnt_o unchanged (0); a 65536-result run wraps op_cnt_o to 0.
